// File: rtl/md_rcv.sv
// rtl/md_rcv.sv - md_io responder capture FIFO, show-ahead read, drop and per-source stats
// Optional per-source accept counters enabled by macro MD_RCV_STATS_EN.
module md_rcv #(
  parameter int DEPTH = 8,
  parameter int AW    = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       en,
  input  logic                       md_we,
  input  logic [AW-1:0]              md_ai,
  output logic                       rd_vld,
  input  logic                       rd_rdy,
  output logic [AW-1:0]              rd_dat,
  output logic [1:0]                 rd_src,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic [7:0]                 drop_cnt,
  output logic [31:0]                stat
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = AW + 2;

  logic [EW-1:0] mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [7:0]    drop_q, drop_d;
  logic          wr_req, push, pop;

  assign rd_vld   = (count_q != '0);
  assign full     = (count_q == CW'(DEPTH));
  assign count    = count_q;
  assign drop_cnt = drop_q;
  assign rd_dat   = mem_q[rd_ptr_q][AW-1:0];
  assign rd_src   = mem_q[rd_ptr_q][AW+1:AW];

  always_comb begin
    wr_req   = en & md_we;
    pop      = rd_vld & rd_rdy;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    push     = wr_req & (~full | pop);
    wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d  = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    drop_d = drop_q;
    if (wr_req && full && !pop && drop_q != 8'hFF) drop_d = drop_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      drop_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      drop_q   <= drop_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {md_ai[4:3], md_ai};
  end

`ifdef MD_RCV_STATS_EN
  logic [7:0] stat_q [4];
  logic [7:0] stat_d [4];

  always_comb begin
    for (int s = 0; s < 4; s++) stat_d[s] = stat_q[s];
    if (push && stat_q[md_ai[4:3]] != 8'hFF)
      stat_d[md_ai[4:3]] = stat_q[md_ai[4:3]] + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < 4; s++) stat_q[s] <= '0;
    end else begin
      for (int s = 0; s < 4; s++) stat_q[s] <= stat_d[s];
    end
  end

  assign stat = {stat_q[3], stat_q[2], stat_q[1], stat_q[0]};
`else
  assign stat = 32'h0;
`endif

endmodule

// File: doc/md_rcv.md
MD_RCV -- requirements
Module: md_rcv

Interface
REQ-001 Parameter DEPTH, default 8, number of FIFO entries; SHALL be a power of two, 2..64.
REQ-002 Parameter AW, default 8, width of md_ai and rd_dat.
REQ-003 Port clk  input  1  single clock; all state SHALL update on posedge clk.
REQ-004 Port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 Port en  input  1  capture enable; md_we is ignored while en=0.
REQ-006 Port md_we  input  1  write strobe from an md_io master (responder end of the md_io we/ai link).
REQ-007 Port md_ai  input  AW  write index/data from the md_io master.
REQ-008 Port rd_vld  output  1  FIFO head valid.
REQ-009 Port rd_rdy  input  1  consumer accepts head.
REQ-010 Port rd_dat  output  AW  head index value.
REQ-011 Port rd_src  output  2  head source ID = captured md_ai[4:3].
REQ-012 Port count  output  $clog2(DEPTH)+1  current occupancy.
REQ-013 Port full  output  1  count==DEPTH.
REQ-014 Port drop_cnt  output  8  saturating count of rejected writes.
REQ-015 Port stat  output  32  per-source accept counters, {src3,src2,src1,src0}, 8 bits each.

Function
REQ-016 Push SHALL occur on posedge when en & md_we & (!full | pop); stored entry = {md_ai[4:3], md_ai}.
REQ-017 Pop SHALL occur on posedge when rd_vld & rd_rdy.
REQ-018 FIFO SHALL be show-ahead: rd_dat/rd_src SHALL present the oldest entry combinationally from storage whenever rd_vld=1.
REQ-019 Push-to-visible latency SHALL be 1 cycle: a value pushed at edge N is on rd_dat with rd_vld=1 after edge N if FIFO was empty.
REQ-020 rd_vld SHALL equal (count!=0); rd_dat/rd_src SHALL be don't-care when rd_vld=0.
REQ-021 count SHALL update +1 on push only, -1 on pop only, unchanged on simultaneous push+pop.
REQ-022 Full with simultaneous pop: push SHALL be accepted, count stays DEPTH.
REQ-023 Empty with simultaneous push: no pop (rd_vld=0); count becomes 1.
REQ-024 Write/read pointers SHALL be $clog2(DEPTH) bits and wrap modulo DEPTH.
REQ-025 en & md_we & full & !pop SHALL be a drop: no state change except drop_cnt +1, saturating at 8'hFF.
REQ-026 md_we with en=0 SHALL neither push nor count as drop.
REQ-027 md_we held high SHALL push one entry per cycle (master holds we=1 continuously; every cycle is a write).

Reset
REQ-028 rst_n=0 SHALL asynchronously clear pointers, count=0, rd_vld=0, full=0, drop_cnt=0, stat=0.
REQ-029 Reset mid-operation SHALL discard all FIFO contents; storage array need not be cleared.
REQ-030 First push SHALL be possible on the first posedge after rst_n deasserts.

Configuration
REQ-031 Macro MD_RCV_STATS_EN defined: stat[8*s+7:8*s] SHALL increment on each push with rd_src s, saturating at 8'hFF.
REQ-032 MD_RCV_STATS_EN undefined: stat SHALL be constant 32'h0 and no counter flops SHALL be synthesized.

Verification
REQ-033 Reset, en=1, we=1, ai=0,1,2 on 3 cycles, rd_rdy=0 -> count=3, rd_dat=0, rd_src=0, rd_vld=1.
REQ-034 Fill 8 entries ai=8..15, rd_rdy=0, 2 more writes -> full=1, count=8, drop_cnt=2, rd_dat=8, rd_src=1.
REQ-035 Full, we=1 ai=24 with rd_rdy=1 -> pop 8, push 24, count=8, drop_cnt unchanged; draining yields 9..15 then 24 with rd_src=3.
REQ-036 Empty, we=1 ai=16 and rd_rdy=1 same cycle -> next cycle count=1, rd_vld=1, rd_dat=16, rd_src=2.
REQ-037 With MD_RCV_STATS_EN, 300 pushes from source 2 with rd_rdy=1 -> stat=32'h00FF_0000; without macro stat=0.
REQ-038 Mid-stream rst_n pulse with count=5 -> count=0, rd_vld=0, drop_cnt=0 immediately, before next clk edge.
